fetch_stage: RTL and testbench

- Instruction-fetch stage of the 5-stage pipeline (IF→ID→EXE→MEM→WB); sits directly upstream of the decode stage and feeds the 62-bit IF→ID bus register.
- Owns the word-addressed PC and drives the synchronous instruction ROM (1-cycle read latency).
- Presents one instruction per cycle under a valid/ready handshake.
- Redirects on EXE jump or on the exception/interrupt flush from the top-level CP0 logic.

---
 rtl/cpu_pkg.sv | 28 ++
 rtl/fetch_stage_if.sv | 16 +
 rtl/fetch_stage.sv | 65 ++++++
 tb/tb_fetch_stage.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared pipeline definitions: IF->ID bus layout, fetch constants, fetch state encoding.
package cpu_pkg;

  localparam int IF_ID_W = 62;
  localparam int PC_LSB  = 32;
  localparam int INS_LSB = 0;

  localparam logic [29:0] DEF_RESET_PC   = 30'h0000_0000;
  localparam logic [29:0] DEF_EXC_VECTOR = 30'h2FF0_00E0;

  typedef enum logic {RST, RUN} fetch_state_e;

  // Next fetch word address; earlier terms have priority.
  function automatic logic [29:0] sel_next_pc(
    input logic        exc_flush,
    input logic        jump,
    input logic [29:0] jump_addr,
    input logic        adv,
    input logic [29:0] pc,
    input logic [29:0] exc_vector
  );
    if (exc_flush)  return exc_vector;
    else if (jump)  return jump_addr;
    else if (adv)   return pc + 30'd1;
    else            return pc;
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// IF->ID handshake and bus; master = fetch stage, slave = decode stage.
interface fetch_stage_if;
  import cpu_pkg::*;

  logic               if_valid;
  logic               id_ready;
  logic               if_finish;
  logic [IF_ID_W-1:0] IF_ID_BUS;
  logic [29:0]        pc_add_8;
  logic               if_adel;

  modport master (output if_valid, if_finish, IF_ID_BUS, pc_add_8, if_adel,
                  input  id_ready);
  modport slave  (input  if_valid, if_finish, IF_ID_BUS, pc_add_8, if_adel,
                  output id_ready);
endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the word PC, drives the 1-cycle sync ROM, redirects on jump/exception.
// Optional macro FETCH_ADEL_EN flags fetches whose PC lies above the ROM address range.
module fetch_stage
  import cpu_pkg::*;
#(
  parameter logic [29:0] RESET_PC   = DEF_RESET_PC,
  parameter logic [29:0] EXC_VECTOR = DEF_EXC_VECTOR,
  parameter int          ROM_AW     = 8
) (
  input  logic              clk,
  input  logic              reset,
  output logic [ROM_AW-1:0] rom_addr,
  input  logic [31:0]       rom_data,
  input  logic              jump,
  input  logic [29:0]       jump_addr,
  input  logic              exc_flush,
  fetch_stage_if.master     fi
);

  fetch_state_e state_q;
  logic [29:0]  pc_q;
  logic [29:0]  pc_nxt;
  logic         data_ok;
  logic         redirect;
  logic         valid;

  // The ROM is always addressed with the value pc_q takes at this edge, so in RUN
  // rom_data always holds the word for the current pc_q.
  always_comb begin
    redirect = exc_flush | jump;
    pc_nxt   = sel_next_pc(exc_flush, jump, jump_addr, fi.id_ready & data_ok, pc_q, EXC_VECTOR);
    rom_addr = (state_q == RST) ? RESET_PC[ROM_AW-1:0] : pc_nxt[ROM_AW-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RST;
      pc_q    <= RESET_PC;
      data_ok <= 1'b0;
    end else begin
      case (state_q)
        RST: begin
          state_q <= RUN;
          pc_q    <= RESET_PC;
          data_ok <= 1'b1;
        end
        default: pc_q <= pc_nxt;
      endcase
    end
  end

  // A redirect kills the sequential word already read for this cycle.
  assign valid        = (state_q == RUN) & data_ok & ~redirect;
  assign fi.if_valid  = valid;
  assign fi.if_finish = valid & fi.id_ready;
  assign fi.IF_ID_BUS = (state_q == RUN) ? {pc_q, rom_data} : {RESET_PC, 32'h0};
  assign fi.pc_add_8  = pc_q + 30'd2;

`ifdef FETCH_ADEL_EN
  assign fi.if_adel = valid & (pc_q[29:ROM_AW] != '0);
`else
  assign fi.if_adel = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: reset, streaming, stall, jump, exception priority, reset-in-stall, wrap.
module tb_fetch_stage;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  rom_addr;
  logic [31:0] rom_data;
  logic        jump;
  logic [29:0] jump_addr;
  logic        exc_flush;
  logic [31:0] rom_mem [256];

  int n_vec  = 0;
  int n_fail = 0;

`ifdef FETCH_ADEL_EN
  localparam logic ADEL_ON = 1'b1;
`else
  localparam logic ADEL_ON = 1'b0;
`endif

  fetch_stage_if fi();

  fetch_stage #(.ROM_AW(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .rom_addr  (rom_addr),
    .rom_data  (rom_data),
    .jump      (jump),
    .jump_addr (jump_addr),
    .exc_flush (exc_flush),
    .fi        (fi.master)
  );

  always #5 clk = ~clk;

  always @(posedge clk) rom_data <= rom_mem[rom_addr];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_bus(input string tag, input logic [29:0] pc, input logic [31:0] ins, input logic vld);
    chk({tag, ".bus"},   64'(fi.IF_ID_BUS), 64'({pc, ins}));
    chk({tag, ".valid"}, 64'(fi.if_valid),  64'(vld));
  endtask

  initial begin
    for (int i = 0; i < 256; i++) rom_mem[i] = 32'h1000_0000 + i;
    reset = 1'b1; jump = 1'b0; jump_addr = '0; exc_flush = 1'b0; fi.id_ready = 1'b1;

    // reset held three cycles
    cyc(); cyc(); cyc(); #1;
    chk("rst.valid",  64'(fi.if_valid),  64'd0);
    chk("rst.finish", 64'(fi.if_finish), 64'd0);
    chk("rst.bus",    64'(fi.IF_ID_BUS), 64'h0);
    chk("rst.pc8",    64'(fi.pc_add_8),  64'd2);
    chk("rst.adel",   64'(fi.if_adel),   64'd0);
    chk("rst.romad",  64'(rom_addr),     64'd0);

    reset = 1'b0;
    cyc(); #1;
    chk_bus("run0", 30'd0, 32'h1000_0000, 1'b1);
    chk("run0.finish", 64'(fi.if_finish), 64'd1);
    chk("run0.romad",  64'(rom_addr),     64'd1);
    for (int p = 1; p <= 4; p++) begin
      cyc(); #1;
      chk_bus("seq", 30'(p), 32'h1000_0000 + 32'(p), 1'b1);
    end

    // stall four cycles at pc 5
    cyc(); fi.id_ready = 1'b0; #1;
    for (int s = 0; s < 4; s++) begin
      if (s != 0) begin cyc(); #1; end
      chk_bus("stall", 30'd5, 32'h1000_0005, 1'b1);
      chk("stall.finish", 64'(fi.if_finish), 64'd0);
    end
    cyc(); fi.id_ready = 1'b1; #1;
    chk_bus("rel5", 30'd5, 32'h1000_0005, 1'b1);
    chk("rel5.finish", 64'(fi.if_finish), 64'd1);
    cyc(); #1;
    chk_bus("pc6", 30'd6, 32'h1000_0006, 1'b1);

    // jump while bus shows pc 7
    cyc(); jump = 1'b1; jump_addr = 30'h40; #1;
    chk("jmp.bus",    64'(fi.IF_ID_BUS[61:32]), 64'd7);
    chk("jmp.valid",  64'(fi.if_valid),  64'd0);
    chk("jmp.finish", 64'(fi.if_finish), 64'd0);
    chk("jmp.romad",  64'(rom_addr),     64'h40);
    cyc(); jump = 1'b0; #1;
    chk_bus("tgt", 30'h40, 32'h1000_0040, 1'b1);
    chk("tgt.pc8", 64'(fi.pc_add_8), 64'h42);
    cyc(); #1;
    chk_bus("tgt1", 30'h41, 32'h1000_0041, 1'b1);

    // exception and jump together: exception vector wins
    exc_flush = 1'b1; jump = 1'b1; jump_addr = 30'h80; #1;
    chk("exc.valid", 64'(fi.if_valid), 64'd0);
    chk("exc.romad", 64'(rom_addr),    64'hE0);
    cyc(); exc_flush = 1'b0; jump = 1'b0; #1;
    chk_bus("vec", 30'h2FF0_00E0, 32'h1000_00E0, 1'b1);
    chk("vec.adel", 64'(fi.if_adel), 64'(ADEL_ON));

    // go to pc 9, stall, then reset during the stall
    jump = 1'b1; jump_addr = 30'd9;
    cyc(); jump = 1'b0; fi.id_ready = 1'b0; #1;
    chk_bus("p9", 30'd9, 32'h1000_0009, 1'b1);
    cyc(); reset = 1'b1; #1;
    chk_bus("p9s", 30'd9, 32'h1000_0009, 1'b1);
    cyc(); #1;
    chk_bus("mrst", 30'd0, 32'h0, 1'b0);
    chk("mrst.pc8", 64'(fi.pc_add_8), 64'd2);
    reset = 1'b0; fi.id_ready = 1'b1;
    cyc(); #1;
    chk_bus("refetch", 30'd0, 32'h1000_0000, 1'b1);

    // out-of-ROM fetch aliases; flagged only with the address-error option
    jump = 1'b1; jump_addr = 30'h100;
    cyc(); jump = 1'b0; #1;
    chk_bus("alias", 30'h100, 32'h1000_0000, 1'b1);
    chk("alias.adel", 64'(fi.if_adel), 64'(ADEL_ON));

    // PC wrap at the top of the 30-bit space
    jump = 1'b1; jump_addr = 30'h3FFF_FFFF;
    cyc(); jump = 1'b0; #1;
    chk_bus("top", 30'h3FFF_FFFF, 32'h1000_00FF, 1'b1);
    chk("top.pc8",   64'(fi.pc_add_8), 64'd1);
    chk("top.romad", 64'(rom_addr),    64'd0);
    cyc(); #1;
    chk_bus("wrap", 30'd0, 32'h1000_0000, 1'b1);
    chk("wrap.adel", 64'(fi.if_adel), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
